// File: rtl/stream_pack_256_1536.sv
`default_nettype none
// ============================================================================
//  Module   : stream_pack_256_1536
//  Purpose  : Packs 256-bit input beats into 1536-bit output words.
//             Each word gathers a configurable number of beats (1..6).
//             A beat carrying tlast closes the word early, and the unused
//             upper slots are zero-filled.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1     rising-edge clock
//    rst_n          in   1     synchronous active-low reset
//    beat_cfg       in   3     beats per word (0 and 7 select 6)
//    s_axis_tdata   in   256   input beat
//    s_axis_tvalid  in   1     input beat valid
//    s_axis_tlast   in   1     last beat of a packet, closes the word
//    s_axis_tready  out  1     input beat accepted when high with tvalid
//    m_axis_tdata   out  1536  packed output word
//    m_axis_tvalid  out  1     output word valid
//    m_axis_tready  in   1     downstream accept
//    word_cnt       out  16    delivered-word counter (wraps)
// ============================================================================
module stream_pack_256_1536 (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2:0]     beat_cfg,
    input  logic [255:0]   s_axis_tdata,
    input  logic           s_axis_tvalid,
    input  logic           s_axis_tlast,
    output logic           s_axis_tready,
    output logic [1535:0]  m_axis_tdata,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,
    output logic [15:0]    word_cnt
);

    localparam int         c_SLOTS     = 6;
    localparam logic [2:0] c_MAX_BEATS = 3'd6;

    logic [255:0]  r_acc [0:c_SLOTS-1];
    logic [2:0]    r_slot;
    logic [2:0]    r_n_lat;
    logic [1535:0] r_out;
    logic          r_out_vld;
    logic [15:0]   r_word_cnt;

    logic [2:0]    w_cfg_eff;
    logic [2:0]    w_n;
    logic          w_complete;
    logic          w_accept;
    logic          w_load;
    logic          w_drain;
    logic [1535:0] w_word;

    // Codes 0 and 7 are not meaningful beat counts; they fall back to a full word.
    assign w_cfg_eff = ((beat_cfg == 3'd0) || (beat_cfg == 3'd7)) ? c_MAX_BEATS : beat_cfg;

    // The first beat of a word uses the live config; later beats use the
    // value latched with that first beat so mid-word changes are ignored.
    assign w_n        = (r_slot == 3'd0) ? w_cfg_eff : r_n_lat;
    assign w_complete = s_axis_tlast || (r_slot == (w_n - 3'd1));

    // Only a completing beat needs the output register, so only it is
    // held off while an undelivered word is still pending.
    assign s_axis_tready = !(r_out_vld && !m_axis_tready && w_complete);

    assign w_accept = s_axis_tvalid && s_axis_tready;
    assign w_load   = w_accept && w_complete;
    assign w_drain  = r_out_vld && m_axis_tready;

    // Word image: filled slots from the accumulator, the current beat in
    // its slot, zeros above.
    generate
        for (genvar gi = 0; gi < c_SLOTS; gi++) begin : g_slot
            localparam logic [2:0] c_IDX = 3'(gi);
            assign w_word[256*gi +: 256] = (c_IDX == r_slot) ? s_axis_tdata :
                                           (c_IDX <  r_slot) ? r_acc[gi]    : 256'd0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot     <= 3'd0;
            r_n_lat    <= c_MAX_BEATS;
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_word_cnt <= 16'd0;
            for (int i = 0; i < c_SLOTS; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                if (r_slot == 3'd0) begin
                    r_n_lat <= w_cfg_eff;
                end
                if (w_complete) begin
                    r_slot <= 3'd0;
                    for (int i = 0; i < c_SLOTS; i++) begin
                        r_acc[i] <= '0;
                    end
                end else begin
                    r_slot        <= r_slot + 3'd1;
                    r_acc[r_slot] <= s_axis_tdata;
                end
            end

            // A load in the same cycle as a drain keeps valid high (no bubble).
            if (w_load) begin
                r_out     <= w_word;
                r_out_vld <= 1'b1;
            end else if (w_drain) begin
                r_out_vld <= 1'b0;
            end

            if (w_drain) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    assign m_axis_tdata  = r_out;
    assign m_axis_tvalid = r_out_vld;
    assign word_cnt      = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_pack_256_1536.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_pack_256_1536
//  Purpose  : Self-checking bench for stream_pack_256_1536. Expected words
//             are queued as stimulus is driven and compared on each output
//             handshake; directed checks cover reset, stall and latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_pack_256_1536;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [2:0]     beat_cfg;
    logic [255:0]   s_tdata;
    logic           s_tvalid;
    logic           s_tlast;
    logic           s_tready;
    logic [1535:0]  m_tdata;
    logic           m_tvalid;
    logic           m_tready;
    logic [15:0]    word_cnt;

    int             total = 0;
    int             bad   = 0;
    int             exp_words = 0;
    logic [1535:0]  sb_q [$];

    always #5 clk = ~clk;

    stream_pack_256_1536 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .beat_cfg      (beat_cfg),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .word_cnt      (word_cnt)
    );

    task automatic chk(input string tag, input logic [1535:0] obs, input logic [1535:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int k);
        mk = {8{32'(k) * 32'h9E37_79B1 + 32'h0000_1000}};
    endfunction

    // Scoreboard: every delivered word must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", m_tdata, 1536'd0);
                total++;
                bad++;
                $error("FAIL unexpected_word observed=%0h expected=none", m_tdata);
            end else begin
                chk("word", m_tdata, sb_q.pop_front());
            end
        end
    end

    task automatic push_word(input logic [1535:0] w);
        sb_q.push_back(w);
        exp_words++;
    endtask

    // Drive one beat; waits (bounded) for tready, then holds through the edge.
    task automatic send(input logic [255:0] d, input logic l);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("send_timeout", 1536'(s_tready), 1536'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain_wait(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk(tag, 1536'(sb_q.size()), 1536'd0);
    endtask

    initial begin
        logic [255:0] b [0:5];
        rst_n    = 1'b0;
        beat_cfg = 3'd6;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tready", 1536'(s_tready), 1536'd1);
        chk("rst_mvalid", 1536'(m_tvalid), 1536'd0);
        chk("rst_mdata",  m_tdata, 1536'd0);
        chk("rst_cnt",    1536'(word_cnt), 1536'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Six beats 1..6, full word, one-cycle latency and one-cycle valid
        beat_cfg = 3'd6;
        push_word({256'd6, 256'd5, 256'd4, 256'd3, 256'd2, 256'd1});
        for (int k = 1; k <= 5; k++) send(256'(k), 1'b0);
        chk("no_early_valid", 1536'(m_tvalid), 1536'd0);
        send(256'd6, 1'b0);
        chk("latency_valid", 1536'(m_tvalid), 1536'd1);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", 1536'(m_tvalid), 1536'd0);
        chk("cnt_after_first", 1536'(word_cnt), 1536'(exp_words));
        drain_wait("drain_full");

        // cfg=3 with tlast on C, then cfg=0 behaves as 6
        beat_cfg = 3'd3;
        for (int k = 0; k < 3; k++) b[k] = mk(10 + k);
        push_word({768'd0, b[2], b[1], b[0]});
        send(b[0], 1'b0);
        send(b[1], 1'b0);
        send(b[2], 1'b1);
        beat_cfg = 3'd0;
        for (int k = 0; k < 6; k++) b[k] = mk(20 + k);
        push_word({b[5], b[4], b[3], b[2], b[1], b[0]});
        for (int k = 0; k < 6; k++) send(b[k], 1'b0);
        beat_cfg = 3'd7;
        for (int k = 0; k < 6; k++) b[k] = mk(30 + k);
        push_word({b[5], b[4], b[3], b[2], b[1], b[0]});
        for (int k = 0; k < 6; k++) send(b[k], 1'b0);
        drain_wait("drain_cfg");

        // tlast on first beat
        beat_cfg = 3'd6;
        push_word({1280'd0, 256'hAB});
        send(256'hAB, 1'b1);
        for (int k = 0; k < 2; k++) b[k] = mk(40 + k);
        beat_cfg = 3'd2;
        push_word({1024'd0, b[1], b[0]});
        send(b[0], 1'b0);
        send(b[1], 1'b0);
        drain_wait("drain_tlast0");

        // Config change mid-word is ignored until the next word
        beat_cfg = 3'd6;
        for (int k = 0; k < 6; k++) b[k] = mk(50 + k);
        push_word({b[5], b[4], b[3], b[2], b[1], b[0]});
        send(b[0], 1'b0);
        beat_cfg = 3'd2;
        for (int k = 1; k < 6; k++) send(b[k], 1'b0);
        for (int k = 0; k < 2; k++) b[k] = mk(60 + k);
        push_word({1024'd0, b[1], b[0]});
        send(b[0], 1'b0);
        send(b[1], 1'b0);
        drain_wait("drain_cfgchg");
        chk("cnt_mid", 1536'(word_cnt), 1536'(exp_words));

        // Backpressure: cfg=2, downstream stalled
        beat_cfg = 3'd2;
        m_tready = 1'b0;
        for (int k = 0; k < 4; k++) b[k] = mk(70 + k);
        push_word({1024'd0, b[1], b[0]});
        push_word({1024'd0, b[3], b[2]});
        send(b[0], 1'b0);
        send(b[1], 1'b0);
        send(b[2], 1'b0);
        s_tdata  = b[3];
        s_tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_tready_low", 1536'(s_tready), 1536'd0);
            chk("stall_valid",      1536'(m_tvalid), 1536'd1);
            chk("stall_data",       m_tdata, {1024'd0, b[1], b[0]});
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        @(negedge clk);
        chk("release_tready", 1536'(s_tready), 1536'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        chk("no_bubble_valid", 1536'(m_tvalid), 1536'd1);
        chk("no_bubble_data",  m_tdata, {1024'd0, b[3], b[2]});
        drain_wait("drain_stall");
        chk("cnt_after_stall", 1536'(word_cnt), 1536'(exp_words));

        // Reset mid-word discards the partial word
        beat_cfg = 3'd6;
        for (int k = 0; k < 3; k++) send(mk(80 + k), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_words = 0;
        chk("rst_mid_valid", 1536'(m_tvalid), 1536'd0);
        chk("rst_mid_cnt",   1536'(word_cnt), 1536'd0);
        for (int k = 0; k < 6; k++) b[k] = mk(90 + k);
        push_word({b[5], b[4], b[3], b[2], b[1], b[0]});
        for (int k = 0; k < 6; k++) send(b[k], 1'b0);
        drain_wait("drain_after_rst");
        chk("cnt_after_rst", 1536'(word_cnt), 1536'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_valid", 1536'(m_tvalid), 1536'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
